// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// The FSM steps each instruction through fetch, decode, execute, memory and
// writeback, and drives every datapath enable and mux select.
// Outputs are decoded from the state register. The only exceptions are IRwrite
// and PCwrite in FETCH, which also depend on MemReady.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   RESET     | held while nReset is low; all outputs 0 (code 0)
//   FETCH     | read instruction at PC; load IR and PC+4 when MemReady
//   DECODE    | precompute branch target into ALUout; branch on opcode
//   R_EXEC    | A op B, with the operation taken from the funct field
//   R_WB      | write ALUout to rd
//   MEM_ADDR  | A + sign-extended imm; split to lw or sw
//   MEM_READ  | data read at ALUout; wait for MemReady
//   MEM_WB    | write MDR to rt
//   MEM_WRITE | data write at ALUout; wait for MemReady
//   BRANCH    | A - B; PC <= ALUout if zero
//   JUMP      | PC <= jump address
//   ADDI_EXEC | A + sign-extended imm
//   ADDI_WB   | write ALUout to rt
//   ILLEGAL   | one-cycle IllegalOp pulse; instruction becomes a NOP
module mips_multicycle_control #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           Clk,
  input  logic           nReset,
  input  logic [OPW-1:0] Opcode,
  input  logic           MemReady,
  output logic           PCwrite,
  output logic           PCwriteCOND,
  output logic [1:0]     PCsource,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRwrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic           IllegalOp,
  output logic [STW-1:0] State
);

  typedef enum logic [STW-1:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_R_EXEC,
    S_R_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JUMP,
    S_ADDI_EXEC,
    S_ADDI_WB,
    S_ILLEGAL
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);

  state_t r_state;
  state_t w_next;

  // State register. Reset drops the FSM to RESET immediately, which in turn
  // clears every output.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode. Unused encodings fall to the default branch.
  // That branch returns the FSM to FETCH with all outputs low.
  always_comb begin
    w_next      = S_FETCH;
    PCwrite     = 1'b0;
    PCwriteCOND = 1'b0;
    PCsource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRwrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    IllegalOp   = 1'b0;

    case (r_state)
      S_RESET: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRwrite = 1'b1;
          PCwrite = 1'b1;
          w_next  = S_DECODE;
        end else begin
          w_next  = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_R_WB;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // An opcode that turned into neither lw nor sw retires as a NOP.
        if (Opcode == OP_LW) begin
          w_next = S_MEM_READ;
        end else if (Opcode == OP_SW) begin
          w_next = S_MEM_WRITE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = MemReady ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = MemReady ? S_FETCH : S_MEM_WRITE;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCwriteCOND = 1'b1;
        PCsource    = 2'b01;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCwrite  = 1'b1;
        PCsource = 2'b10;
        w_next   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_ILLEGAL: begin
        IllegalOp = 1'b1;
        w_next    = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  assign State = r_state;

endmodule
